recip_div_sched: RTL and testbench

//  Shares one reciprocal-LUT divide datapath among NUM_REQ requesters. Arbitrates round-robin,

---
 rtl/recip_div_pkg.sv | 18 +
 rtl/recip_div_sched_if.sv | 28 ++
 rtl/recip_div_sched_arbiter.sv | 43 ++++
 rtl/recip_div_sched.sv | 126 ++++++++++++
 tb/tb_recip_div_sched.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/recip_div_pkg.sv
// Shared types and constants for the reciprocal-LUT divide scheduler.
// Configuration macro: RECIP_DIV_INTERP_EN (consumed by recip_div_sched).
package recip_div_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    INTERP = 3'd2,
    MULT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam int          QSHIFT_DEF  = 15;
  localparam logic [15:0] SAT_MAX     = 16'hFFFF;
  // Divisors below this have no LUT entry (only the upper byte indexes it).
  localparam logic [15:0] MIN_LUT_DIV = 16'd256;

endpackage

// File: rtl/recip_div_sched_if.sv
// Request/response bundle between the DSP requesters/consumer and recip_div_sched.
interface recip_div_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_dividend;
  logic [16*NUM_REQ-1:0] req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [15:0]           rsp_quotient;
  logic                  rsp_dbz;
  logic                  rsp_range_err;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_dbz, rsp_range_err
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_dbz, rsp_range_err
  );

endinterface

// File: rtl/recip_div_sched_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer,
// and moves the pointer past the winner only when the grant is accepted.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_req
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    any_req   = 1'b0;
    idx       = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // Wrap explicitly so non-power-of-two NUM_REQ never points at a missing requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/recip_div_sched.sv
// Shares one reciprocal-LUT divide datapath among NUM_REQ requesters (round-robin).
// Define RECIP_DIV_INTERP_EN to interpolate between adjacent LUT entries.
module recip_div_sched
  import recip_div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int QSHIFT  = QSHIFT_DEF,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  recip_div_sched_if.slave   bus,
  output logic [15:0]        lut_divisor,
  input  logic [15:0]        lut_recip_base,
  input  logic [15:0]        lut_recip_next
);

  state_t state_q, state_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               any_req;
  logic               accept;
  logic [15:0]        sel_dividend;
  logic [15:0]        sel_divisor;
  logic [15:0]        dividend_q;
  logic [15:0]        base_q;
  logic [15:0]        recip_sel;
  logic [31:0]        mult_prod;
  logic [31:0]        mult_shift;
  logic [15:0]        quotient_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign accept        = (state_q == IDLE) && any_req;
  assign bus.req_ready = ((state_q == IDLE) && rst_n) ? grant : '0;
  assign bus.rsp_valid = (state_q == RESP);
  assign sel_dividend  = bus.req_dividend[16*grant_idx +: 16];
  assign sel_divisor   = bus.req_divisor[16*grant_idx +: 16];

`ifdef RECIP_DIV_INTERP_EN
  logic [15:0] next_q;
  logic [15:0] recip_q;
  logic [15:0] delta;
  logic [23:0] interp_prod;
  logic [15:0] interp_corr;

  // lut_divisor still holds the job's divisor, so its low byte is the fraction.
  assign delta       = base_q - next_q;
  assign interp_prod = {8'd0, delta} * {16'd0, lut_divisor[7:0]};
  assign interp_corr = 16'(interp_prod >> 8);
  assign recip_sel   = recip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_q  <= '0;
      recip_q <= '0;
    end else begin
      if (state_q == LOOKUP) next_q  <= lut_recip_next;
      if (state_q == INTERP) recip_q <= base_q - interp_corr;
    end
  end
`else
  logic unused_next;
  assign unused_next = ^lut_recip_next;
  assign recip_sel   = base_q;
`endif

  assign mult_prod  = {16'd0, dividend_q} * {16'd0, recip_sel};
  assign mult_shift = mult_prod >> QSHIFT;
  assign quotient_d = (mult_shift > 32'(SAT_MAX)) ? SAT_MAX : mult_shift[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = (sel_divisor < MIN_LUT_DIV) ? RESP : LOOKUP;
`ifdef RECIP_DIV_INTERP_EN
      LOOKUP: state_d = INTERP;
      INTERP: state_d = MULT;
`else
      LOOKUP: state_d = MULT;
`endif
      MULT:   state_d = RESP;
      RESP:   if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The LUT address is loaded at accept so base/next have settled by the end of LOOKUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_divisor       <= '0;
      dividend_q        <= '0;
      base_q            <= '0;
      bus.rsp_id        <= '0;
      bus.rsp_quotient  <= '0;
      bus.rsp_dbz       <= 1'b0;
      bus.rsp_range_err <= 1'b0;
    end else begin
      if (accept) begin
        lut_divisor       <= sel_divisor;
        dividend_q        <= sel_dividend;
        bus.rsp_id        <= grant_idx;
        bus.rsp_dbz       <= (sel_divisor == 16'd0);
        bus.rsp_range_err <= (sel_divisor != 16'd0) && (sel_divisor < MIN_LUT_DIV);
        if (sel_divisor < MIN_LUT_DIV) bus.rsp_quotient <= SAT_MAX;
      end
      if (state_q == LOOKUP) base_q           <= lut_recip_base;
      if (state_q == MULT)   bus.rsp_quotient <= quotient_d;
    end
  end

endmodule

// File: tb/tb_recip_div_sched.sv
// Directed self-checking bench for recip_div_sched with a Q1.15 reciprocal LUT stand-in.
// Expected latency/quotients follow the RECIP_DIV_INTERP_EN setting of the build.
module tb_recip_div_sched;

  localparam int NUM_REQ = 4;
`ifdef RECIP_DIV_INTERP_EN
  localparam int          LAT  = 4;
  localparam logic [15:0] Q_T2 = 16'h00D5;
`else
  localparam int          LAT  = 3;
  localparam logic [15:0] Q_T2 = 16'h0100;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] lut_divisor;
  logic [15:0] lut_recip_base;
  logic [15:0] lut_recip_next;
  logic [7:0]  lut_idx;
  int          checks = 0;
  int          errors = 0;
  int          lat;
  int          wait_cnt;
  int          exp_i;

  recip_div_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  recip_div_sched #(.NUM_REQ(NUM_REQ), .QSHIFT(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .lut_divisor    (lut_divisor),
    .lut_recip_base (lut_recip_base),
    .lut_recip_next (lut_recip_next)
  );

  always #5 clk = ~clk;

  // LUT stand-in: base = 2^23 / (idx*256); next is the entry half a step further on.
  always_comb begin
    lut_idx        = lut_divisor[15:8];
    lut_recip_base = 16'hFFFF;
    lut_recip_next = 16'hFFFF;
    if (lut_idx != 8'd0) begin
      lut_recip_base = 16'(32'h0080_0000 / {16'd0, lut_idx, 8'd0});
      lut_recip_next = 16'(32'h0080_0000 / ({16'd0, lut_idx, 8'd0} + 32'd128));
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic [15:0] dividend, input logic [15:0] divisor);
    bus.req_dividend[16*idx +: 16] = dividend;
    bus.req_divisor[16*idx +: 16]  = divisor;
    bus.req_valid[idx]             = 1'b1;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 1;
    @(negedge clk);
    while (!bus.rsp_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_job(input int idx, input logic [15:0] dividend, input logic [15:0] divisor,
                         input logic [15:0] exp_q, input logic exp_dbz, input logic exp_rng,
                         input int exp_lat, input string tag);
    int c;
    apply_stimulus(idx, dividend, divisor);
    #1;
    check_output({tag, "_ready"}, 32'(bus.req_ready), 32'(1) << idx);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    wait_rsp(c);
    check_output({tag, "_latency"}, 32'(c), 32'(exp_lat));
    check_output({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
    check_output({tag, "_quotient"}, 32'(bus.rsp_quotient), 32'(exp_q));
    check_output({tag, "_dbz"}, 32'(bus.rsp_dbz), 32'(exp_dbz));
    check_output({tag, "_range_err"}, 32'(bus.rsp_range_err), 32'(exp_rng));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check_output({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check_output("reset_lut_divisor", 32'(lut_divisor), 32'd0);
    check_output("reset_quotient", 32'(bus.rsp_quotient), 32'd0);
    check_output("reset_id", 32'(bus.rsp_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(0, 16'd1234, 16'h0100, 16'd1234, 1'b0, 1'b0, LAT, "t1");
    check_output("t1_lut_divisor", 32'(lut_divisor), 32'h0100);
    run_job(1, 16'h0100, 16'h0180, Q_T2, 1'b0, 1'b0, LAT, "t2");
    run_job(2, 16'd500, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1, "t3_dbz");
    run_job(3, 16'd1000, 16'h00FF, 16'hFFFF, 1'b0, 1'b1, 1, "t3_range");

    // All requesters held valid: grants must rotate 0,1,2,3,0.
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 16'(10 * (i + 1)), 16'h0100);
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_i    = k % NUM_REQ;
      wait_cnt = 0;
      while (bus.req_ready == '0 && wait_cnt < 20) begin
        @(negedge clk);
        wait_cnt++;
      end
      check_output("rr_grant", 32'(bus.req_ready), 32'(1) << exp_i);
      @(posedge clk);
      #1;
      wait_rsp(lat);
      check_output("rr_id", 32'(bus.rsp_id), 32'(exp_i));
      check_output("rr_quotient", 32'(bus.rsp_quotient), 32'(10 * (exp_i + 1)));
      if (k == 4) bus.req_valid = '0;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;

    // 0xFFFF * 0x0100 >> 15 = 0x01FF
    run_job(1, 16'hFFFF, 16'h8000, 16'h01FF, 1'b0, 1'b0, LAT, "big");

    // Consumer stalls for 10 cycles while every requester waits.
    apply_stimulus(2, 16'd777, 16'h0100);
    #1;
    check_output("stall_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk);
    #1;
    bus.req_valid = 4'hF;
    wait_rsp(lat);
    check_output("stall_latency", 32'(lat), 32'(LAT));
    for (int c = 0; c < 10; c++) begin
      check_output("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check_output("stall_quotient", 32'(bus.rsp_quotient), 32'd777);
      check_output("stall_id", 32'(bus.rsp_id), 32'd2);
      check_output("stall_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check_output("stall_idle_grant", 32'(bus.req_ready), 32'h8);
    bus.req_valid = '0;
    @(negedge clk);
    check_output("stall_rsp_drop", 32'(bus.rsp_valid), 32'd0);

    // Reset during LOOKUP drops the job and restarts the pointer at requester 0.
    apply_stimulus(1, 16'h0100, 16'h0100);
    #1;
    check_output("rst_ready", 32'(bus.req_ready), 32'h2);
    @(posedge clk);
    #1;
    bus.req_valid = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_output("rst_lut_divisor", 32'(lut_divisor), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("rst_first_grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    wait_rsp(lat);
    check_output("rst_job_latency", 32'(lat), 32'(LAT));
    check_output("rst_job_id", 32'(bus.rsp_id), 32'd0);
    check_output("rst_job_quotient", 32'(bus.rsp_quotient), 32'd10);

    $display("[TB] directed sequence complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
